// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-multiplexes one shared hex-to-seven-segment
// decoder across NUM_DIGITS common-anode digits. Each digit slot is a blanking
// gap (all anodes off, next nibble already presented to the decoder) followed
// by a drive window. Display values are double-buffered and swap only on the
// frame wrap, so a frame never mixes old and new digits.
// Optional build macro: LEADING_ZERO_SUPPRESS_EN (blank leading zero digits).
module seg_scan_controller #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 100000,
  parameter int BLANK_CYCLES   = 1000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       value_in,
  input  logic                          load,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  output logic [3:0]                    number,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int MAX_C = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);

  // Terminal counts; a zero-length blank is never entered so its value is moot.
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t                  state_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [4*NUM_DIGITS-1:0] active_r;
  logic [4*NUM_DIGITS-1:0] pending_r;
  logic                    pending_valid_r;

  state_t                  state_nxt_s;
  logic [CNT_W-1:0]        cnt_nxt_s;
  logic [IDX_W-1:0]        idx_nxt_s;
  logic                    wrap_s;
  logic [4*NUM_DIGITS-1:0] active_nxt_s;
  logic [4*NUM_DIGITS-1:0] pending_nxt_s;
  logic                    pending_valid_nxt_s;
  logic [NUM_DIGITS-1:0]   anode_nxt_s;
  logic [3:0]              number_nxt_s;

`ifdef LEADING_ZERO_SUPPRESS_EN
  // True when this digit and every more-significant digit are zero, except
  // digit 0, which always shows so a zero value still displays "0".
  function automatic logic lead_zero(input logic [4*NUM_DIGITS-1:0] v,
                                     input logic [IDX_W-1:0]        idx);
    logic all_zero;
    all_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(idx)) && (v[4*i +: 4] != 4'h0)) begin
        all_zero = 1'b0;
      end else begin
        all_zero = all_zero;
      end
    end
    return all_zero && (idx != '0);
  endfunction
`endif

  // Next-state: slot timing, digit advance, buffer swap and the output image.
  always_comb begin
    state_nxt_s         = state_r;
    cnt_nxt_s           = cnt_r + CNT_W'(1);
    idx_nxt_s           = digit_idx;
    wrap_s              = 1'b0;
    active_nxt_s        = active_r;
    pending_nxt_s       = pending_r;
    pending_valid_nxt_s = pending_valid_r;

    case (state_r)
      ST_BLANK: begin
        if (cnt_r == BLANK_LAST) begin
          state_nxt_s = ST_DRIVE;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_BLANK;
        end
      end
      ST_DRIVE: begin
        if (cnt_r == DRIVE_LAST) begin
          cnt_nxt_s   = '0;
          wrap_s      = (digit_idx == LAST_IDX);
          idx_nxt_s   = (digit_idx == LAST_IDX) ? '0 : digit_idx + IDX_W'(1);
          state_nxt_s = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
        end else begin
          state_nxt_s = ST_DRIVE;
        end
      end
      default: begin
        state_nxt_s = ST_BLANK;
        cnt_nxt_s   = '0;
      end
    endcase

    // Last load in a frame wins; it waits in pending until the wrap.
    if (load) begin
      pending_nxt_s       = value_in;
      pending_valid_nxt_s = 1'b1;
    end else begin
      pending_nxt_s       = pending_r;
    end

    // On the wrap a same-edge load goes straight to active.
    if (wrap_s) begin
      pending_valid_nxt_s = 1'b0;
      if (load) begin
        active_nxt_s = value_in;
      end else if (pending_valid_r) begin
        active_nxt_s = pending_r;
      end else begin
        active_nxt_s = active_r;
      end
    end else begin
      active_nxt_s = active_r;
    end

    // Nibble is presented during blank too so the decoder settles early.
    number_nxt_s = active_nxt_s[{idx_nxt_s, 2'b00} +: 4];

    anode_nxt_s = '1;
    if (state_nxt_s == ST_DRIVE) begin
`ifdef LEADING_ZERO_SUPPRESS_EN
      anode_nxt_s[idx_nxt_s] = ~digit_en[idx_nxt_s] | lead_zero(active_nxt_s, idx_nxt_s);
`else
      anode_nxt_s[idx_nxt_s] = ~digit_en[idx_nxt_s];
`endif
    end else begin
      anode_nxt_s = '1;
    end
  end

  // Scan FSM state, buffers and registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ST_BLANK;
      cnt_r           <= '0;
      digit_idx       <= '0;
      active_r        <= '0;
      pending_r       <= '0;
      pending_valid_r <= 1'b0;
      anode           <= '1;
      number          <= 4'h0;
      frame_done      <= 1'b0;
    end else begin
      state_r         <= state_nxt_s;
      cnt_r           <= cnt_nxt_s;
      digit_idx       <= idx_nxt_s;
      active_r        <= active_nxt_s;
      pending_r       <= pending_nxt_s;
      pending_valid_r <= pending_valid_nxt_s;
      anode           <= anode_nxt_s;
      number          <= number_nxt_s;
      frame_done      <= wrap_s;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with NUM_DIGITS=4, REFRESH_CYCLES=8,
// BLANK_CYCLES=2. Cycle c counts from the first cycle after reset release; a
// frame is 40 cycles: digit d blanks at 40f+10d..+1 and drives at 40f+10d+2..+9.
module tb_seg_scan_controller;

  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value_in;
  logic        load;
  logic [3:0]  digit_en;
  logic [3:0]  number;
  logic [3:0]  anode;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  seg_scan_controller #(
    .NUM_DIGITS    (N),
    .REFRESH_CYCLES(R),
    .BLANK_CYCLES  (B)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .value_in  (value_in),
    .load      (load),
    .digit_en  (digit_en),
    .number    (number),
    .anode     (anode),
    .digit_idx (digit_idx),
    .frame_done(frame_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    value_in = 16'h0000;
    digit_en = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;

    // Reset state and first frame timing
    chk("rst_anode", anode, 4'hF);
    chk("rst_number", number, 4'h0);
    chk("rst_idx", digit_idx, 2'd0);
    chk("rst_fd", frame_done, 1'b0);
    go(1);  chk("blank0_b", anode, 4'hF);
    go(2);  chk("drive0_start", anode, 4'hE);
    go(9);  chk("drive0_end", anode, 4'hE);
    go(10); chk("blank1_anode", anode, 4'hF);
            chk("blank1_idx", digit_idx, 2'd1);
    go(12); chk("drive1_anode", anode, 4'hD);
    go(39); chk("fd_before", frame_done, 1'b0);
            chk("drive3_anode", anode, 4'h7);
            chk("drive3_idx", digit_idx, 2'd3);
    go(40); chk("fd_pulse1", frame_done, 1'b1);
            chk("wrap_idx", digit_idx, 2'd0);
            chk("wrap_anode", anode, 4'hF);
    go(41); chk("fd_one_cycle", frame_done, 1'b0);

    // Mid-frame load shows only after the next wrap
    go(45);
    value_in = 16'h1234; load = 1'b1;
    tick();
    load = 1'b0;
    go(62); chk("old_data_num", number, 4'h0);
            chk("old_data_anode", anode, 4'hB);
    go(79); chk("fd_quiet", frame_done, 1'b0);
    go(80); chk("fd_pulse2", frame_done, 1'b1);
            chk("blank_early_num", number, 4'h4);

    go(82); chk("f2_d0_num", number, 4'h4);
            chk("f2_d0_anode", anode, 4'hE);

    // Two loads in one frame: the last wins
    go(85);
    value_in = 16'hAAAA; load = 1'b1;
    tick();
    value_in = 16'h5555;
    tick();
    load = 1'b0;
    go(92);  chk("f2_d1_num", number, 4'h3);
             chk("f2_d1_anode", anode, 4'hD);
    go(102); chk("f2_d2_num", number, 4'h2);
             chk("f2_d2_anode", anode, 4'hB);
    go(112); chk("f2_d3_num", number, 4'h1);
             chk("f2_d3_anode", anode, 4'h7);
    go(122); chk("last_wins_d0", number, 4'h5);
             chk("f3_d0_anode", anode, 4'hE);
    go(152); chk("last_wins_d3", number, 4'h5);

    // Load on the wrap edge bypasses pending
    go(159);
    value_in = 16'hBEEF; load = 1'b1;
    tick();
    load = 1'b0;
    chk("wrapload_blank_num", number, 4'hF);
    chk("fd_pulse4", frame_done, 1'b1);
    go(162); chk("wrapload_d0", number, 4'hF);
             chk("wrapload_d0_anode", anode, 4'hE);
    go(172); chk("wrapload_d1", number, 4'hE);
    go(182); chk("wrapload_d2", number, 4'hE);
    go(192); chk("wrapload_d3", number, 4'hB);
             chk("wrapload_d3_anode", anode, 4'h7);

    // Per-digit enable
    go(195);
    digit_en = 4'b0101;
    go(202); chk("en_d0", anode, 4'hE);
    go(212); chk("en_d1_off", anode, 4'hF);
             chk("en_d1_idx", digit_idx, 2'd1);
    go(222); chk("en_d2", anode, 4'hB);
    go(232); chk("en_d3_off", anode, 4'hF);
    go(239); chk("en_fd_before", frame_done, 1'b0);
    go(240); chk("en_fd_period", frame_done, 1'b1);
    go(244);
    digit_en = 4'b0100;
    tick();
    chk("toggle_off", anode, 4'hF);
    digit_en = 4'b0101;
    tick();
    chk("toggle_on", anode, 4'hE);
    chk("toggle_num", number, 4'hF);
    digit_en = 4'hF;

    // Reset during DRIVE of digit 2
    go(265);
    chk("pre_rst_idx", digit_idx, 2'd2);
    reset = 1'b1;
    tick();
    chk("mid_rst_anode", anode, 4'hF);
    chk("mid_rst_idx", digit_idx, 2'd0);
    chk("mid_rst_number", number, 4'h0);
    chk("mid_rst_fd", frame_done, 1'b0);
    reset = 1'b0;
    cyc   = 0;
    go(1); chk("rerun_blank", anode, 4'hF);
    go(2); chk("rerun_drive", anode, 4'hE);
           chk("rerun_active_clear", number, 4'h0);

    // Leading-zero behaviour on 0070 and 0000
    go(3);
    value_in = 16'h0070; load = 1'b1;
    tick();
    load = 1'b0;
    go(12); chk("still_zero_num", number, 4'h0);
            chk("still_zero_anode", anode, 4'hD);
    go(42); chk("lz_d0_num", number, 4'h0);
            chk("lz_d0_anode", anode, 4'hE);
    go(52); chk("lz_d1_num", number, 4'h7);
            chk("lz_d1_anode", anode, 4'hD);
`ifdef LEADING_ZERO_SUPPRESS_EN
    go(62); chk("lz_d2_anode", anode, 4'hF);
    go(72); chk("lz_d3_anode", anode, 4'hF);
`else
    go(62); chk("lz_d2_anode", anode, 4'hB);
    go(72); chk("lz_d3_anode", anode, 4'h7);
`endif
    go(75);
    value_in = 16'h0000; load = 1'b1;
    tick();
    load = 1'b0;
    go(82); chk("z_d0_num", number, 4'h0);
            chk("z_d0_anode", anode, 4'hE);
`ifdef LEADING_ZERO_SUPPRESS_EN
    go(92);  chk("z_d1_anode", anode, 4'hF);
    go(102); chk("z_d2_anode", anode, 4'hF);
    go(112); chk("z_d3_anode", anode, 4'hF);
`else
    go(92);  chk("z_d1_anode", anode, 4'hD);
    go(102); chk("z_d2_anode", anode, 4'hB);
    go(112); chk("z_d3_anode", anode, 4'h7);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
Time-multiplexes one shared 4-bit hex-to-seven-segment decoder across NUM_DIGITS common-anode digits. Each digit is driven for a fixed on-time, with a blanking gap between digits to prevent ghosting. Display values are double-buffered and update only at frame boundaries, so a frame never shows a mix of old and new digits. The `number` output feeds the decoder; `anode` drives the board's digit enables directly.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
REFRESH_CYCLES, 100000, clk cycles each digit is driven (>=1)
BLANK_CYCLES, 1000, clk cycles all anodes are off before each digit (>=0)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
value_in  input  4*NUM_DIGITS  nibble i = digit i; digit 0 is rightmost
load  input  1  capture value_in on this clk edge
digit_en  input  NUM_DIGITS  per-digit enable; 0 keeps that anode off
number  output  4  nibble to the decoder, registered
anode  output  NUM_DIGITS  active-low digit enables, registered
digit_idx  output  $clog2(NUM_DIGITS)  index of the digit currently scheduled
frame_done  output  1  one-cycle pulse when the scan wraps from the last digit to digit 0

Behaviour:
- Reset values:
  - anode = all 1s; number = 0; digit_idx = 0; frame_done = 0.
  - Pending and active buffers = 0; pending_valid = 0; state = BLANK; counter = 0.
- Reset mid-scan takes effect on the next edge, regardless of state.
- States:
  - BLANK: anode all 1s; number = active nibble[digit_idx]. Presenting it early lets the decoder settle before the digit turns on.
  - DRIVE: anode[digit_idx] = ~digit_en[digit_idx]; all other anode bits = 1.
- BLANK -> DRIVE after BLANK_CYCLES cycles in BLANK.
- If BLANK_CYCLES = 0, BLANK lasts 0 cycles: the controller goes straight from one DRIVE to the next, and number changes on the same edge as anode.
- DRIVE -> BLANK after REFRESH_CYCLES cycles. On this edge:
  - digit_idx increments, wrapping NUM_DIGITS-1 -> 0.
  - The counter clears.
- Frame period = NUM_DIGITS*(BLANK_CYCLES+REFRESH_CYCLES) cycles, exactly.
- Wrap edge (digit_idx NUM_DIGITS-1 -> 0):
  - frame_done = 1 for the following cycle only.
  - If pending_valid, active <= pending and pending_valid clears.
- load:
  - pending <= value_in; pending_valid <= 1.
  - Repeated loads within a frame: the last one wins.
- load on the wrap edge: active <= value_in directly, bypassing pending; pending_valid <= 0.
- Load-to-visible latency: up to one frame, plus BLANK_CYCLES for digit 0.
- Changing digit_en takes effect on the next edge, including mid-DRIVE. Timing is unaffected by digit_en.
- Counter width = $clog2(max(REFRESH_CYCLES, BLANK_CYCLES)+1). The counter never exceeds its terminal value.

Optional Feature:
Macro: LEADING_ZERO_SUPPRESS_EN.
- Defined:
  - During DRIVE, the anode also stays off if every active nibble from digit_idx up to NUM_DIGITS-1 is zero and digit_idx != 0.
  - Digit 0 always shows, so value 0 displays "0".
  - Suppression is computed from the active buffer only.
- Undefined: all enabled digits show, leading zeros included. No suppression logic is synthesized.

Test Plan:
Common config for every case: NUM_DIGITS=4, REFRESH_CYCLES=8, BLANK_CYCLES=2.
1. Reset held 3 cycles, then released -> anode=4'b1111, number=0, digit_idx=0 for 2 cycles; then anode=4'b1110 for 8 cycles; then 2 cycles of 4'b1111 with digit_idx=1; frame_done pulses every 40 cycles.
2. load with value_in=16'h1234 mid-frame, digit_en=4'hF -> current frame keeps old data. After the next frame_done, number sequences 4,3,2,1 with anode 1110, 1101, 1011, 0111 during the DRIVE phases.
3. load 16'hAAAA then 16'h5555 in the same frame -> next frame shows only 5s. load asserted on the wrap edge with 16'hBEEF -> the immediately following frame shows F,E,E,B.
4. digit_en=4'b0101 -> anode[1] and anode[3] stay 1 throughout their DRIVE slots; frame period still 40 cycles. Toggling digit_en[0] mid-DRIVE changes anode[0] on the next edge.
5. Reset asserted during DRIVE of digit 2 -> next edge: anode=4'b1111, digit_idx=0, active=0. Scan restarts with a 2-cycle BLANK.
6. (LEADING_ZERO_SUPPRESS_EN) value 16'h0070 -> digits 3 and 2 off, 7 then 0 shown. Value 16'h0000 -> only digit 0 lit, showing 0. Without the macro, all four digits are lit.
